// File: rtl/video_timing_gen.sv
// video_timing_gen: raster beam counters, pixel enable, sync/blank decode and frame strobe
// for the spot generators and the video output path, all on one clock via a CE divider.
module video_timing_gen #(
    parameter int CE_DIV       = 4,
    parameter int H_TOTAL      = 400,
    parameter int H_ACTIVE     = 320,
    parameter int H_SYNC_START = 336,
    parameter int H_SYNC_END   = 366,
    parameter int V_TOTAL      = 262,
    parameter int V_ACTIVE     = 240,
    parameter int V_SYNC_START = 244,
    parameter int V_SYNC_END   = 247
) (
    input  logic       clk,
    input  logic       reset,
    output logic       ce_pix,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       frame_start
);
    localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS     = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE     = 10'(H_SYNC_END);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS     = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE     = 10'(V_SYNC_END);

    logic [3:0] div;
    logic       h_wrap, v_wrap;
    logic [9:0] h_next, v_next;

    // Decode from the next counter values so sync/blank move on the same edge as the counters.
    always_comb begin
        h_wrap = h_count == H_LAST;
        v_wrap = v_count == V_LAST;
        h_next = ce_pix ? (h_wrap ? '0 : h_count + 10'd1) : h_count;
        v_next = (ce_pix && h_wrap) ? (v_wrap ? '0 : v_count + 10'd1) : v_count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div         <= '0;
            ce_pix      <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= (div == DIV_LAST) ? '0 : div + 4'd1;
            ce_pix      <= div == DIV_LAST;
            h_count     <= h_next;
            v_count     <= v_next;
            hsync       <= h_next >= H_SS && h_next < H_SE;
            vsync       <= v_next >= V_SS && v_next < V_SE;
            hblank      <= h_next >= H_ACT;
            vblank      <= v_next >= V_ACT;
            frame_start <= ce_pix && h_wrap && v_wrap;
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: three raster configurations under random resets, scored against an
// arithmetic model of beam position derived from clocks elapsed since reset release.
module tb_video_timing_gen;
    localparam int N = 3;
    localparam int D   [N] = '{4, 5, 2};
    localparam int HT  [N] = '{400, 40, 10};
    localparam int HA  [N] = '{320, 32, 6};
    localparam int HSS [N] = '{336, 34, 7};
    localparam int HSE [N] = '{366, 37, 9};
    localparam int VT  [N] = '{262, 30, 4};
    localparam int VA  [N] = '{240, 24, 3};
    localparam int VSS [N] = '{244, 25, 3};
    localparam int VSE [N] = '{247, 27, 4};
    localparam int CYCLES = 8000;

    logic        clk = 1'b0;
    logic        rst [N];
    logic [25:0] obs [N];
    logic [25:0] exp_q [N][$];
    int          checks = 0;
    int          passes = 0;
    bit          started = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic       ce, hs, vs, hb, vb, fs;
        logic [9:0] h, v;
        video_timing_gen #(
            .CE_DIV(D[g]), .H_TOTAL(HT[g]), .H_ACTIVE(HA[g]),
            .H_SYNC_START(HSS[g]), .H_SYNC_END(HSE[g]),
            .V_TOTAL(VT[g]), .V_ACTIVE(VA[g]),
            .V_SYNC_START(VSS[g]), .V_SYNC_END(VSE[g])
        ) u_dut (
            .clk(clk), .reset(rst[g]), .ce_pix(ce), .h_count(h), .v_count(v),
            .hsync(hs), .vsync(vs), .hblank(hb), .vblank(vb), .frame_start(fs)
        );
        assign obs[g] = {ce, h, v, hs, vs, hb, vb, fs};
    end

    // n = clock edges since reset was last sampled; pixels elapsed follow from n alone.
    function automatic logic [25:0] model(int i, int n);
        int p, h, v;
        logic ce, fs;
        ce = n > 0 && n % D[i] == 0;
        p  = n > 0 ? (n - 1) / D[i] : 0;
        h  = p % HT[i];
        v  = (p / HT[i]) % VT[i];
        fs = n > 1 && (n - 1) % D[i] == 0 && p % (HT[i] * VT[i]) == 0;
        return {ce, 10'(h), 10'(v), h >= HSS[i] && h < HSE[i], v >= VSS[i] && v < VSE[i],
                h >= HA[i], v >= VA[i], fs};
    endfunction

    function automatic int next_gap(int i);
        return i == 0 ? int'($urandom_range(500, 3000)) :
               i == 1 ? int'($urandom_range(1000, 3000)) : int'($urandom_range(100, 400));
    endfunction

    initial begin
        int n [N];
        int at [N];
        int len [N];
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1;
            n[i]   = 0;
            len[i] = 1;
            at[i]  = i == 1 ? 5 + int'($urandom_range(6200, 6800)) : 5 + next_gap(i);
        end
        for (int c = 0; c < CYCLES; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                rst[i] = c < 5 || (c >= at[i] && c < at[i] + len[i]);
                if (c == at[i] + len[i] - 1) begin
                    at[i]  = c + 1 + next_gap(i);
                    len[i] = int'($urandom_range(1, 3));
                end
                n[i] = rst[i] ? 0 : n[i] + 1;
                exp_q[i].push_back(model(i, n[i]));
            end
            started = 1'b1;
        end
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    always @(posedge clk) begin
        if (started) begin
            #1;
            for (int i = 0; i < N; i++) begin
                logic [25:0] e;
                checks++;
                if (exp_q[i].size() == 0) begin
                    $display("FAIL raster[%0d] no expectation queued, got %h", i, obs[i]);
                end else begin
                    e = exp_q[i].pop_front();
                    if (obs[i] === e) passes++;
                    else $display("FAIL raster[%0d] @%0t got ce=%0b h=%0d v=%0d hs/vs/hb/vb/fs=%05b want ce=%0b h=%0d v=%0d hs/vs/hb/vb/fs=%05b",
                                  i, $time, obs[i][25], obs[i][24:15], obs[i][14:5], obs[i][4:0],
                                  e[25], e[24:15], e[14:5], e[4:0]);
                end
                checks++;
                if (int'(obs[i][24:15]) < HT[i] && int'(obs[i][14:5]) < VT[i]) passes++;
                else $display("FAIL range[%0d] @%0t got h=%0d v=%0d limits %0d/%0d",
                              i, $time, obs[i][24:15], obs[i][14:5], HT[i], VT[i]);
            end
        end
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Upstream raster timing source for the spot generators (player, ball, wall).
- Produces free-running horizontal and vertical beam counters. These are the HORIZ and VERT inputs every spot generator compares against.
- Also produces a pixel clock enable, sync, blanking and a frame-start strobe for the video output path.
- All timing is derived from the single system clock through a clock-enable divider; there is no second clock domain.

Parameters:
- CE_DIV, 4: system clocks per pixel; legal range 2..16.
- H_TOTAL, 400: pixels per line, including blanking.
- H_ACTIVE, 320: visible pixels; hblank for h_count >= H_ACTIVE.
- H_SYNC_START, 336: first h_count with hsync asserted.
- H_SYNC_END, 366: first h_count after hsync (exclusive end).
- V_TOTAL, 262: lines per frame.
- V_ACTIVE, 240: visible lines; vblank for v_count >= V_ACTIVE.
- V_SYNC_START, 244: first line with vsync asserted.
- V_SYNC_END, 247: first line after vsync (exclusive end).

Ports:
- clk, input, 1: system clock. All logic is on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- ce_pix, output, 1: one-clk-wide pixel enable, once every CE_DIV clocks.
- h_count, output, 10: horizontal position, 0..H_TOTAL-1.
- v_count, output, 10: vertical position, 0..V_TOTAL-1.
- hsync, output, 1: active-high horizontal sync.
- vsync, output, 1: active-high vertical sync.
- hblank, output, 1: horizontal blanking.
- vblank, output, 1: vertical blanking.
- frame_start, output, 1: one-clk pulse when the raster enters (0,0).

Behaviour:
- All outputs are registered. Reset values:
  - ce_pix=0, h_count=0, v_count=0.
  - hsync=0, vsync=0, hblank=0, vblank=0, frame_start=0.
- Reset is synchronous: sampled on the clk edge, and dominant over every other event.
  - Asserting reset mid-line or mid-frame returns all state to its reset values on the next edge.
  - No partial update occurs in the cycle reset is sampled.
- Divider:
  - A counter div cycles 0..CE_DIV-1; it is cleared by reset.
  - ce_pix is registered high in the cycle after div==CE_DIV-1.
  - After reset deasserts, the first ce_pix is high in the CE_DIV-th clock.
  - ce_pix is then periodic with period CE_DIV and is never high in two consecutive clocks.
- Counters change only on clk edges where ce_pix is high. They hold otherwise.
  - h_count increments; from H_TOTAL-1 it wraps to 0.
  - v_count increments only on the edge where h_count wraps; from V_TOTAL-1 it wraps to 0.
  - Both counters therefore wrap on the same edge at end of frame.
- Decoded outputs are computed from the next counter values and registered on the same edge. hsync, vsync, hblank and vblank thus change on exactly the edge where h_count/v_count change, with zero offset from the counters:
  - hblank = (h_count >= H_ACTIVE)
  - vblank = (v_count >= V_ACTIVE)
  - hsync = (H_SYNC_START <= h_count < H_SYNC_END)
  - vsync = (V_SYNC_START <= v_count < V_SYNC_END); vsync is line-granular and changes only when h_count wraps.
- frame_start:
  - High for exactly one clk, on the edge where both counters wrap to 0.
  - Not asserted by reset itself.
- Width and arithmetic:
  - Counters are unsigned, 10 bits.
  - Parameters must satisfy H_ACTIVE <= H_SYNC_START < H_SYNC_END <= H_TOTAL <= 1024, and the vertical equivalents. Violations are a configuration error; no runtime checking.
- Counter values must never leave their ranges. A bench assertion checks h_count < H_TOTAL and v_count < V_TOTAL on every clock.

Test Plan:
- Reset release: hold reset 5 clks, release -> all outputs 0; ce_pix first high in clock 4 after release, then every 4 clocks; h_count=1 after the first ce_pix edge.
- Line wrap: run to h_count=399 -> next ce edge gives h_count=0, v_count incremented by 1; hblank high for h_count 320..399; hsync high exactly for h_count 336..365 (30 pixels = 120 clks).
- Frame wrap: run to (399,261) -> next ce edge gives (0,0) with frame_start high for 1 clk; frame period = 400*262*4 = 419200 clks between frame_start pulses.
- Vertical decode: vblank is high for lines 240..261 and vsync for lines 244..246 only. Both change only on the h-wrap edge; neither changes mid-line.
- Mid-frame reset: assert reset at (150,100) for 1 clk -> next edge all outputs 0; ce_pix restarts with the 4-clock phase from release.
- Non-default CE_DIV=2, H_TOTAL=10, V_TOTAL=4, other parameters scaled to legal values -> ce_pix alternates 0/1; frame_start every 80 clks; counters stay in range throughout.
